mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
- Round-robin arbitration stage that sits directly upstream of the 4:1 mux datapath.
- Picks one of four requesting sources and drives the 2-bit select (sel: in1=00, in2=01, in3=10, in4=11).
- Captures the selected source's data into an output register and presents it downstream over a valid/ready handshake.
- Guarantees fair, starvation-free access for four producers sharing one consumer.

Parameters:
- WIDTH, 1, data width of each input and of out.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req  input  4  request per source; req[0]=in1 … req[3]=in4
- in1  input  WIDTH  source 0 data
- in2  input  WIDTH  source 1 data
- in3  input  WIDTH  source 2 data
- in4  input  WIDTH  source 3 data
- grant  output  4  one-hot, one-cycle pulse; acknowledges the source whose data was captured
- sel  output  2  index of the source held in out
- out  output  WIDTH  registered selected data
- out_valid  output  1  out and sel are valid
- out_ready  input  1  downstream accepts out this cycle
- busy  output  1  high while out_valid=1 and out_ready=0 (stalled)

Behaviour:
- Reset values (async assert, sync release): sel=00, out=0, out_valid=0, grant=0000, busy=0, internal priority pointer ptr=0.
- Reset mid-transfer discards the held word; no grant is issued for it.
- Load condition: load = (out_valid==0) || out_ready.
- On a clock edge with load=1 and any req bit = 1:
  - Winner i is the first set req bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - out <= in(i+1), sel <= i, out_valid <= 1, grant <= one-hot(i) for exactly that cycle, ptr <= (i+1) mod 4.
- On a clock edge with load=1 and req=0000: out_valid <= 0; out and sel retain their values; grant <= 0000; ptr unchanged.
- On a clock edge with load=0 (stall): out, sel, out_valid and ptr all hold; grant <= 0000.
- Latency: req asserted before edge N gives out_valid=1 after edge N (1 cycle).
- Throughput: with out_ready held at 1, one word per cycle. A handshake and a new capture happen on the same edge (back-to-back).
- Wrap-around: ptr after a grant to source 3 becomes 0.
- Single requester: re-granted every load cycle, because a lone requester always wins regardless of ptr.
- Source protocol:
  - A source holds req and its data stable until it sees its grant pulse.
  - It may deassert req in the cycle after the grant, or keep req high to request again.
  - Data of non-requesting sources is ignored.
- Unknown values:
  - A req bit that is X or Z is treated as not requesting.
  - Captured data passes through bit-for-bit, including X and Z.
  - An X/Z on out_ready stalls (treated as 0).
- grant and out_valid are registered; there is no combinational path from req/in*/out_ready to any output.

Test Plan:
- Reset, then req=0000 for 3 cycles, out_ready=1 → out_valid=0, sel=00, out=0, grant=0000 throughout. Assert rst mid-stall while out_valid=1 → out_valid=0 immediately, before the next clk edge.
- req=1111 held, in1..in4=1,0,0,1, out_ready=1 for 8 cycles → sel sequence 00,01,10,11,00,01,10,11; out sequence 1,0,0,1,1,0,0,1; grant sequence 0001,0010,0100,1000 repeating.
- req=0100 only, in3=1, out_ready=1 for 4 cycles → sel=10, out=1 every cycle, grant=0100 every cycle, ptr settles at 3 with no starvation of the lone requester.
- Capture with req=0011, then out_ready=0 for 3 cycles → out, sel=00 stable, busy=1, grant=0000 during the stall. Raise out_ready → next edge captures source 1 (sel=01), busy=0.
- req=1001, ptr=3 after a prior grant to source 2 → source 3 wins first (sel=11), then wrap gives source 0 (sel=00).
- req=0001, in1=X, then in1=Z → out=X, then out=Z, with sel=00. Then req[1]=X with req=0 elsewhere → no grant, and out_valid falls after the handshake.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux4_rr_arbiter
//
// Round-robin arbitration stage in front of a 4:1 data mux. Each cycle the
// output register can accept a word, it picks one requesting source and
// captures that source's data. The search starts at a rotating priority
// pointer, so every source is served within four load cycles.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   req[3:0]   per-source request; req[0]=in1 ... req[3]=in4
//   in1..in4   source data, WIDTH bits each
//   grant[3:0] one-hot, one-cycle acknowledge of the source just captured
//   sel[1:0]   index of the source whose word is held in out
//   out        registered selected data
//   out_valid  out/sel hold a word not yet taken downstream
//   out_ready  downstream accepts out this cycle
//   busy       out_valid=1 while out_ready=0 (output stalled)
// -----------------------------------------------------------------------------
module mux4_rr_arbiter #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       req,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [WIDTH-1:0] in3,
   input  logic [WIDTH-1:0] in4,
   output logic [3:0]       grant,
   output logic [1:0]       sel,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy
);

   logic [1:0]       r_ptr;
   logic [1:0]       r_sel;
   logic [WIDTH-1:0] r_out;
   logic             r_valid;
   logic [3:0]       r_grant;

   logic [3:0]       w_req;
   logic             w_ready;
   logic             w_load;
   logic             w_found;
   logic [1:0]       w_win;
   logic [1:0]       w_idx;
   logic [WIDTH-1:0] w_data;

   // Only a definite 1 counts: X/Z on a request bit means "not requesting",
   // and X/Z on out_ready means "stall".
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         w_req[k] = (req[k] === 1'b1);
      end
   end

   assign w_ready = (out_ready === 1'b1);

   // The register can take a new word when it is empty or being drained now.
   assign w_load = !r_valid || w_ready;

   // Rotating priority search: scanning offsets from 3 down to 0 lets the
   // smallest offset from r_ptr overwrite any later candidate, so the first
   // requester at or after the pointer wins.
   // NOTE: every combinational output gets a default before any conditional
   // assignment, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_found = 1'b0;
      w_win   = 2'd0;
      w_idx   = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         w_idx = r_ptr + 2'(k);
         if (w_req[w_idx]) begin
            w_found = 1'b1;
            w_win   = w_idx;
         end
      end
   end

   always_comb begin
      w_data = in1;
      case (w_win)
         2'd0:    w_data = in1;
         2'd1:    w_data = in2;
         2'd2:    w_data = in3;
         default: w_data = in4;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr   <= 2'd0;
         r_sel   <= 2'd0;
         r_out   <= '0;
         r_valid <= 1'b0;
         r_grant <= 4'b0000;
      end else begin
         // grant is a single-cycle pulse unless a capture happens this edge.
         r_grant <= 4'b0000;
         if (w_load) begin
            if (w_found) begin
               r_out   <= w_data;
               r_sel   <= w_win;
               r_valid <= 1'b1;
               r_grant <= 4'b0001 << w_win;
               r_ptr   <= w_win + 2'd1;  // wraps 3 -> 0
            end else begin
               // Nothing to capture: drop valid, keep out/sel/ptr as they are.
               r_valid <= 1'b0;
            end
         end
      end
   end

   assign grant     = r_grant;
   assign sel       = r_sel;
   assign out       = r_out;
   assign out_valid = r_valid;
   // busy describes the current cycle's handshake, so it follows out_ready
   // directly rather than waiting for an edge.
   assign busy      = r_valid && !w_ready;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux4_rr_arbiter
//
// Directed bench for mux4_rr_arbiter (WIDTH=1). Inputs change 1 time unit
// after a rising edge; outputs are sampled at the same point, well away
// from the next edge.
// -----------------------------------------------------------------------------
module tb_mux4_rr_arbiter;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic       in1, in2, in3, in4;
   logic [3:0] grant;
   logic [1:0] sel;
   logic       out;
   logic       out_valid;
   logic       out_ready;
   logic       busy;

   int n_cmp;
   int n_bad;

   mux4_rr_arbiter #(.WIDTH(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .in1       (in1),
      .in2       (in2),
      .in3       (in3),
      .in4       (in4),
      .grant     (grant),
      .sel       (sel),
      .out       (out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Checks the full output set after a capture.
   task automatic check_word(input string tag, input logic [1:0] e_sel,
                             input logic e_out, input logic [3:0] e_grant);
      check({tag, ".valid"}, 32'(out_valid), 32'd1);
      check({tag, ".sel"},   32'(sel),       32'(e_sel));
      check({tag, ".out"},   32'(out),       32'(e_out));
      check({tag, ".grant"}, 32'(grant),     32'(e_grant));
   endtask

   logic       exp_rr_out [4];
   logic       x_bit;
   logic       z_bit;
   logic [3:0] req_x;

   initial begin
      n_cmp = 0;
      n_bad = 0;
      exp_rr_out[0] = 1'b1;
      exp_rr_out[1] = 1'b0;
      exp_rr_out[2] = 1'b0;
      exp_rr_out[3] = 1'b1;

      rst = 1'b1; req = 4'b0000; out_ready = 1'b0;
      in1 = 1'b0; in2 = 1'b0; in3 = 1'b0; in4 = 1'b0;
      #1;
      check("rst.valid", 32'(out_valid), 32'd0);
      check("rst.sel",   32'(sel),       32'd0);
      check("rst.out",   32'(out),       32'd0);
      check("rst.grant", 32'(grant),     32'd0);
      check("rst.busy",  32'(busy),      32'd0);
      step();
      step();
      rst = 1'b0;

      // Idle: no requests, consumer ready.
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("idle%0d.valid", i), 32'(out_valid), 32'd0);
         check($sformatf("idle%0d.sel", i),   32'(sel),       32'd0);
         check($sformatf("idle%0d.out", i),   32'(out),       32'd0);
         check($sformatf("idle%0d.grant", i), 32'(grant),     32'd0);
      end

      // All four requesting: strict rotation 0,1,2,3,0,...
      req = 4'b1111;
      in1 = 1'b1; in2 = 1'b0; in3 = 1'b0; in4 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         check_word($sformatf("rr%0d", i), 2'(i % 4), exp_rr_out[i % 4],
                    4'b0001 << (i % 4));
      end

      // Lone requester on source 2 wins every cycle.
      req = 4'b0100;
      in1 = 1'b0; in2 = 1'b0; in3 = 1'b1; in4 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check_word($sformatf("lone%0d", i), 2'd2, 1'b1, 4'b0100);
      end

      // Drain, then capture with downstream stalled (ptr=3: scan 3,0 -> 0).
      req = 4'b0000;
      step();
      check("drain.valid", 32'(out_valid), 32'd0);
      req = 4'b0011; in1 = 1'b1; in2 = 1'b0; out_ready = 1'b0;
      step();
      check_word("stcap", 2'd0, 1'b1, 4'b0001);
      check("stcap.busy", 32'(busy), 32'd1);
      for (int i = 0; i < 3; i++) begin
         step();
         check_word($sformatf("stall%0d", i), 2'd0, 1'b1, 4'b0000);
         check($sformatf("stall%0d.busy", i), 32'(busy), 32'd1);
      end
      out_ready = 1'b1;
      #1;
      check("ready.busy", 32'(busy), 32'd0);
      step();
      check_word("unstall", 2'd1, 1'b0, 4'b0010);
      check("unstall.busy", 32'(busy), 32'd0);

      // Grant source 2 to move ptr to 3, then req=1001: 3 first, then wrap to 0.
      req = 4'b0100; in3 = 1'b1;
      step();
      check_word("pre_wrap", 2'd2, 1'b1, 4'b0100);
      req = 4'b1001; in1 = 1'b0; in4 = 1'b1;
      step();
      check_word("wrap_a", 2'd3, 1'b1, 4'b1000);
      step();
      check_word("wrap_b", 2'd0, 1'b0, 4'b0001);

      // Stall with a word held, then reset mid-stall: valid drops at once.
      out_ready = 1'b0;
      step();
      check_word("hold", 2'd0, 1'b0, 4'b0000);
      check("hold.busy", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      check("midrst.valid", 32'(out_valid), 32'd0);
      check("midrst.grant", 32'(grant),     32'd0);
      check("midrst.busy",  32'(busy),      32'd0);
      check("midrst.sel",   32'(sel),       32'd0);
      step();
      rst = 1'b0;

      // Unknown data passes through bit-for-bit.
      x_bit = 1'bx;
      z_bit = 1'bz;
      out_ready = 1'b1;
      req = 4'b0001; in1 = x_bit;
      step();
      check_word("xdata", 2'd0, x_bit, 4'b0001);
      in1 = z_bit;
      step();
      check_word("zdata", 2'd0, z_bit, 4'b0001);

      // Unknown request bit: only a definite 1 counts as a request.
      req_x = 4'b0000;
      req_x[1] = x_bit;
      req = req_x;
      in2 = 1'b1;
      step();
      if (req_x[1] === 1'b1) begin
         check("xreq.grant", 32'(grant),     32'b0010);
         check("xreq.valid", 32'(out_valid), 32'd1);
      end else begin
         check("xreq.grant", 32'(grant),     32'b0000);
         check("xreq.valid", 32'(out_valid), 32'd0);
         check("xreq.sel",   32'(sel),       32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
